// File: rtl/parking_gate_ctrl.sv
// Parking lot barrier controller: free-slot tracking, timed barrier hold, full/empty flags and reject pulses.
// Define PARK_PENDING_EN to queue busy or priority-losing requests (one deep per direction) instead of dropping them.
module parking_gate_ctrl #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned GATE_CYCLES = 80_000_000
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                entry_pulse,
    input  logic                                exit_pulse,
    output logic [$clog2(CAPACITY+1)-1:0]       free_slots,
    output logic                                full,
    output logic                                empty,
    output logic                                entry_gate,
    output logic                                exit_gate,
    output logic                                reject
);

    localparam int unsigned CNT_W = $clog2(CAPACITY + 1);
    localparam int unsigned TMR_W = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   free_q, free_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               entry_gate_q, entry_gate_d;
    logic               exit_gate_q, exit_gate_d;
    logic               reject_q, reject_d;
    logic               entry_req, exit_req, exit_acc;

`ifdef PARK_PENDING_EN
    logic               pend_entry_q, pend_entry_d;
    logic               pend_exit_q, pend_exit_d;
`endif

    // Next-state, counter and output computation
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        free_d       = free_q;
        entry_gate_d = entry_gate_q;
        exit_gate_d  = exit_gate_q;
        reject_d     = 1'b0;
        exit_acc     = 1'b0;
`ifdef PARK_PENDING_EN
        pend_entry_d = pend_entry_q;
        pend_exit_d  = pend_exit_q;
        entry_req    = entry_pulse | pend_entry_q;
        exit_req     = exit_pulse | pend_exit_q;
`else
        entry_req    = entry_pulse;
        exit_req     = exit_pulse;
`endif

        case (state_q)
            IDLE: begin
                // Exit first: it frees a slot, and a rejected exit still lets entry through this edge
                if (exit_req) begin
`ifdef PARK_PENDING_EN
                    pend_exit_d = 1'b0;
`endif
                    if (free_q != CNT_W'(CAPACITY)) begin
                        exit_acc    = 1'b1;
                        state_d     = EXIT_OPEN;
                        exit_gate_d = 1'b1;
                        free_d      = free_q + CNT_W'(1);
                        timer_d     = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                if (entry_req) begin
                    if (exit_acc) begin
`ifdef PARK_PENDING_EN
                        pend_entry_d = 1'b1;
`endif
                    end else begin
`ifdef PARK_PENDING_EN
                        pend_entry_d = 1'b0;
`endif
                        if (free_q != CNT_W'(0)) begin
                            state_d      = ENTRY_OPEN;
                            entry_gate_d = 1'b1;
                            free_d       = free_q - CNT_W'(1);
                            timer_d      = '0;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
`ifdef PARK_PENDING_EN
                if (entry_pulse) pend_entry_d = 1'b1;
                if (exit_pulse)  pend_exit_d  = 1'b1;
`endif
                if (timer_q == TMR_W'(GATE_CYCLES - 1)) begin
                    state_d      = IDLE;
                    timer_d      = '0;
                    entry_gate_d = 1'b0;
                    exit_gate_d  = 1'b0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d      = IDLE;
                timer_d      = '0;
                entry_gate_d = 1'b0;
                exit_gate_d  = 1'b0;
            end
        endcase

        full_d  = (free_d == CNT_W'(0));
        empty_d = (free_d == CNT_W'(CAPACITY));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            free_q       <= CNT_W'(CAPACITY);
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            entry_gate_q <= 1'b0;
            exit_gate_q  <= 1'b0;
            reject_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            free_q       <= free_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            entry_gate_q <= entry_gate_d;
            exit_gate_q  <= exit_gate_d;
            reject_q     <= reject_d;
        end
    end

`ifdef PARK_PENDING_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_entry_q <= 1'b0;
            pend_exit_q  <= 1'b0;
        end else begin
            pend_entry_q <= pend_entry_d;
            pend_exit_q  <= pend_exit_d;
        end
    end
`endif

    assign free_slots = free_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign entry_gate = entry_gate_q;
    assign exit_gate  = exit_gate_q;
    assign reject     = reject_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Scoreboard bench for parking_gate_ctrl with CAPACITY=2, GATE_CYCLES=4; honours PARK_PENDING_EN.
module tb_parking_gate_ctrl;

    localparam int unsigned CAPACITY    = 2;
    localparam int unsigned GATE_CYCLES = 4;

    typedef struct packed {
        logic [1:0] slots;
        logic       full;
        logic       empty;
        logic       eg;
        logic       xg;
        logic       rej;
    } obs_t;

    typedef struct packed {
        logic ent;
        logic ext;
        obs_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       entry_pulse = 1'b0;
    logic       exit_pulse = 1'b0;
    logic [1:0] free_slots;
    logic       full, empty, entry_gate, exit_gate, reject;

    int vectors = 0;
    int miscompares = 0;
    vec_t sb_q[$];

    parking_gate_ctrl #(.CAPACITY(CAPACITY), .GATE_CYCLES(GATE_CYCLES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .entry_pulse(entry_pulse),
        .exit_pulse (exit_pulse),
        .free_slots (free_slots),
        .full       (full),
        .empty      (empty),
        .entry_gate (entry_gate),
        .exit_gate  (exit_gate),
        .reject     (reject)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {free_slots, full, empty, entry_gate, exit_gate, reject};
    endfunction

    // Queue n cycles of stimulus (pulse only on the first) with the expected post-edge outputs
    task automatic push(input int n, input logic e, input logic x, input logic [1:0] s,
                        input logic fu, input logic em, input logic eg, input logic xg, input logic rj);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.ent = (i == 0) ? e : 1'b0;
            v.ext = (i == 0) ? x : 1'b0;
            v.exp = {s, fu, em, eg, xg, rj};
            sb_q.push_back(v);
        end
    endtask

    task automatic drive(input logic e, input logic x);
        entry_pulse = e;
        exit_pulse  = x;
        @(posedge clk);
        #1;
        entry_pulse = 1'b0;
        exit_pulse  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        entry_pulse = 1'b0;
        exit_pulse  = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        do_reset();
        want = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        got = sample();
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL reset_state got=%b want=%b", got, want);
        end
        push(2, 0, 0, 2'd2, 0, 1, 0, 0, 0);
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_idle got=%b want=%b", got, v.exp);
            end
        end
    endtask

    task automatic test_full_reject();
        obs_t got;
        int step = 0;
        do_reset();
        push(4, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
        push(4, 1, 0, 2'd0, 1, 0, 1, 0, 0);
        push(1, 0, 0, 2'd0, 1, 0, 0, 0, 0);
        push(1, 1, 0, 2'd0, 1, 0, 0, 0, 1);
        push(2, 0, 0, 2'd0, 1, 0, 0, 0, 0);
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL entry_full step%0d got=%b want=%b", step, got, v.exp);
            end
        end
    endtask

    task automatic test_exit_empty();
        obs_t got;
        int step = 0;
        do_reset();
        push(1, 0, 1, 2'd2, 0, 1, 0, 0, 1);
        push(1, 0, 0, 2'd2, 0, 1, 0, 0, 0);
        // Rejected exit does not block a same-edge entry
        push(1, 1, 1, 2'd1, 0, 0, 1, 0, 1);
        push(3, 0, 0, 2'd1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL exit_empty step%0d got=%b want=%b", step, got, v.exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        obs_t got;
        int step = 0;
        do_reset();
        push(4, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
        push(4, 1, 1, 2'd2, 0, 1, 0, 1, 0);
        push(1, 0, 0, 2'd2, 0, 1, 0, 0, 0);
`ifdef PARK_PENDING_EN
        push(4, 0, 0, 2'd1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
`else
        push(5, 0, 0, 2'd2, 0, 1, 0, 0, 0);
`endif
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL simultaneous step%0d got=%b want=%b", step, got, v.exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        int step = 0;
        do_reset();
        push(2, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        push(2, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 2'd1, 0, 0, 0, 0, 0);
`ifdef PARK_PENDING_EN
        push(4, 0, 0, 2'd0, 1, 0, 1, 0, 0);
        push(1, 0, 0, 2'd0, 1, 0, 0, 0, 0);
`else
        push(5, 0, 0, 2'd1, 0, 0, 0, 0, 0);
`endif
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL back_to_back step%0d got=%b want=%b", step, got, v.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got;
        int step = 0;
        do_reset();
        push(3, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_mid_pre step%0d got=%b want=%b", step, got, v.exp);
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        push(1, 0, 0, 2'd2, 0, 1, 0, 0, 0);
        begin
            vec_t v = sb_q.pop_front();
            got = sample();
            vectors++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_mid_async got=%b want=%b", got, v.exp);
            end
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        push(1, 0, 0, 2'd2, 0, 1, 0, 0, 0);
        push(1, 1, 0, 2'd1, 0, 0, 1, 0, 0);
        while (sb_q.size() > 0) begin
            vec_t v = sb_q.pop_front();
            drive(v.ent, v.ext);
            got = sample();
            vectors++;
            step++;
            if (got !== v.exp) begin
                miscompares++;
                $display("FAIL reset_mid_post step%0d got=%b want=%b", step, got, v.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_reject();
        test_exit_empty();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
